// File: rtl/pc_fetch_unit.sv
// Architectural PC owner and fetch FSM (REQ -> WAIT -> HOLD, >= 3 cycles/instruction); holds request and instruction stable under backpressure.
// FETCH_MISALIGN_TRAP_EN: redirect misaligned next_pc to TRAP_PC and pulse fetch_err, otherwise the low PC bits are cleared.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_Add4,
  output logic [31:0] fetch_count,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_count;
  logic        r_err;

  logic        w_req_vld;
  logic        w_resp_take;
  logic        w_accept;
  logic        w_misalign;
  logic        w_trap_take;
  logic [31:0] w_pc_nxt;

  // r_run keeps the request channel quiet during any cycle that follows a reset edge.
  assign w_req_vld  = r_run && (r_state == ST_REQ);
  assign w_misalign = (next_pc[1:0] != 2'b00);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_trap_take = w_misalign;
`else
  assign w_trap_take = 1'b0;
`endif

  assign w_pc_nxt = w_trap_take ? TRAP_PC : (next_pc & 32'hFFFF_FFFC);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_REQ;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_resp_take = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (w_req_vld && imem_req_ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          w_resp_take = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (inst_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
      end
    endcase
  end

  // next_pc is only consumed on the decode-accept edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_count <= 32'h0000_0000;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept && w_trap_take && w_misalign;
      if (w_resp_take) begin
        r_instr <= imem_resp_data;
      end
      if (w_accept) begin
        r_pc    <= w_pc_nxt;
        r_count <= r_count + 32'd1;
      end
    end
  end

  assign imem_req_valid = w_req_vld;
  assign imem_addr      = r_pc;
  assign inst_valid     = (r_state == ST_HOLD);
  assign instruction    = r_instr;
  assign pc             = r_pc;
  assign pc_Add4        = r_pc + 32'd4;
  assign fetch_count    = r_count;
  assign fetch_err      = r_err;

endmodule
